// File: rtl/memory_reader_pkg.sv
// memory_reader_pkg: shared types for the memory_reader streaming read engine.
//   reader_state_t - FSM states: idle, reading (capturing words), draining (waiting for the
//                    final beat to be accepted downstream).
package memory_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } reader_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO that decouples bank capture from the output handshake.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (flushes contents, head reads 0)
//   push       - write push_data this cycle (dropped if full and not popping)
//   push_data  - entry to write
//   full       - both entries occupied
//   pop        - remove the head entry this cycle (ignored if empty)
//   head       - oldest entry
//   empty      - no entries held
// A push and a pop in the same cycle are both honoured, including when full.
module stream_skid_fifo #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  logic [WIDTH-1:0] entry0_q, entry1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one popped this cycle.
  assign do_push = push & (~full | do_pop);

  assign head = rd_ptr_q ? entry1_q : entry0_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) begin
          entry1_q <= push_data;
        end else begin
          entry0_q <= push_data;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_reader.sv
// memory_reader: streaming read engine for a memory_cell bank.
// On start it walks `length` consecutive addresses from base_addr (wrapping modulo DEPTH),
// captures each combinational read word and streams the words out on a valid/ready
// interface with a last flag; done pulses for one cycle after the final beat is accepted.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (abandons any transfer)
//   start               - request a transfer (only honoured while idle)
//   base_addr, length   - first address and word count, sampled with start
//   busy                - engine not idle
//   done                - one-cycle completion pulse
//   mem_addr, mem_data  - bank address out, combinational bank read data in
//   out_data, out_last  - stream word and end-of-transfer marker
//   out_valid, out_ready- stream handshake
module memory_reader
  import memory_reader_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned BIT_SIZE = 16,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW:0]         length,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       mem_addr,
  input  logic [BIT_SIZE-1:0] mem_data,
  output logic [BIT_SIZE-1:0] out_data,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  reader_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic          done_q, done_d;

  logic              fifo_full, fifo_empty;
  logic              pop, capture, last_word;
  logic [BIT_SIZE:0] fifo_head;

  assign pop       = out_valid & out_ready;
  assign last_word = (remaining_q == (AW+1)'(1));
  // Capture whenever the FIFO has room, counting a slot freed by this cycle's pop.
  assign capture   = (state_q == StRead) & (~fifo_full | pop);

  stream_skid_fifo #(
    .WIDTH (BIT_SIZE + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data ({mem_data, last_word}),
    .full      (fifo_full),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head[BIT_SIZE:1];
  assign out_last  = fifo_head[0];
  assign mem_addr  = addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = base_addr;
            remaining_d = length;
            state_d     = StRead;
          end
        end
      end
      StRead: begin
        if (capture) begin
          addr_d      = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
          remaining_d = remaining_q - (AW+1)'(1);
          if (last_word) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_memory_reader.sv
module tb_memory_reader;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BW    = 16;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_data;
  logic [BW-1:0] out_data;
  logic          out_last, out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] bank [DEPTH];
  assign mem_data = bank[mem_addr];

  always #5 clk = ~clk;

  memory_reader #(
    .DEPTH    (DEPTH),
    .BIT_SIZE (BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Drive a start at the current negedge; returns at the next negedge (cycle 1).
  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW+1)'($urandom);
  endtask

  // Scenario: one transfer checked beat by beat against the expected word list.
  // mode 0: ready always high, 1: ready alternating, 2: ready random.
  // poke: pulse start (different args) while busy; it must be ignored.
  // Returns at the negedge of the cycle in which done should be high.
  task automatic run_stream(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                            input bit poke);
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] held_data;
    logic          held_last;
    bit            hold;
    int            idx, cyc;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(bank[(int'(b) + i) % DEPTH]);
    out_ready = (mode == 0);
    start_xfer(b, l);
    if (l == '0) begin
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_len_done: done=%b busy=%b valid=%b, required 1 0 0",
                 done, busy, out_valid);
      end
      return;
    end
    idx  = 0;
    cyc  = 0;
    hold = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (idx < int'(l) && cyc < 100) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = (($urandom % 4) != 0);
      endcase
      start = poke && (cyc == 1);
      if (start) begin
        base_addr = b + AW'(3);
        length    = (AW+1)'(3);
      end
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_during: busy=%b done=%b at cyc %0d, required 1 0", busy, done, cyc);
      end
      if (cyc == 0) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid: valid=%b in cycle 1, required 0", out_valid);
        end
      end
      if (cyc >= 1 && (mode == 0 || cyc == 1)) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL valid_timing: valid=%b at cycle %0d, required 1", out_valid, cyc + 1);
        end
      end
      if (mode == 0 && cyc < int'(l)) begin
        n_checks++;
        if (mem_addr !== AW'((int'(b) + cyc) % DEPTH)) begin
          n_fail++;
          $display("FAIL addr_walk: mem_addr=%0d, required %0d", mem_addr,
                   (int'(b) + cyc) % DEPTH);
        end
      end
      if (hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
          n_fail++;
          $display("FAIL stall_stable: valid=%b data=%h last=%b, required 1 %h %b",
                   out_valid, out_data, out_last, held_data, held_last);
        end
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_data !== exp_q[idx] || out_last !== (idx == int'(l) - 1)) begin
          n_fail++;
          $display("FAIL beat_%0d: data=%h last=%b, required %h %b", idx, out_data, out_last,
                   exp_q[idx], (idx == int'(l) - 1));
        end
      end
      hold      = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid === 1'b1 && out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (cyc >= 100) begin
      n_fail++;
      $display("FAIL stream_timeout: %0d beats seen, required %0d", idx, l);
      return;
    end
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 0",
               done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    length = '0;
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_addr !== '0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b addr=%0d valid=%b last=%b data=%h, required 0",
               busy, done, mem_addr, out_valid, out_last, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_stream(3'd2, 4'd4, 0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: done=%b after pulse, required 0", done);
    end
  endtask

  task automatic test_wrap();
    run_stream(3'd6, 4'd4, 0, 1'b0);
  endtask

  task automatic test_alternating();
    run_stream(3'd0, 4'd8, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    int popped, cyc;
    popped = 0;
    cyc = 0;
    out_ready = 1'b1;
    start_xfer(3'd0, 4'd8);
    while (popped < 8 && cyc < 60) begin
      // Stall for 5 cycles once three words have been taken.
      out_ready = !(popped == 3 && cyc >= 4 && cyc < 9);
      if (popped == 3 && cyc >= 5 && cyc < 9) begin
        n_checks++;
        if (mem_addr !== 3'd5) begin
          n_fail++;
          $display("FAIL addr_freeze: mem_addr=%0d at cyc %0d, required 5", mem_addr, cyc);
        end
      end
      if (popped == 4 && cyc == 10) begin
        n_checks++;
        if (mem_addr !== 3'd6) begin
          n_fail++;
          $display("FAIL addr_resume: mem_addr=%0d, required 6", mem_addr);
        end
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_data !== bank[popped] || out_last !== (popped == 7)) begin
          n_fail++;
          $display("FAIL bp_beat_%0d: data=%h last=%b, required %h %b", popped, out_data,
                   out_last, bank[popped], (popped == 7));
        end
        if (out_ready) popped++;
      end
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc >= 60 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: done=%b popped=%0d, required 1 8", done, popped);
    end
  endtask

  task automatic test_zero_length();
    run_stream(3'd3, 4'd0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_len_idle: done=%b busy=%b valid=%b, required 0 0 0",
                 done, busy, out_valid);
      end
    end
  endtask

  task automatic test_start_rules();
    run_stream(3'd0, 4'd4, 0, 1'b1);
    // Start again in the done cycle: must be accepted.
    run_stream(3'd1, 4'd2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int popped, cyc;
    popped = 0;
    cyc = 0;
    out_ready = 1'b1;
    start_xfer(3'd0, 4'd8);
    while (popped < 3 && cyc < 20) begin
      if (out_valid === 1'b1) popped++;
      cyc++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_addr !== '0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b addr=%0d valid=%b last=%b data=%h, required 0",
               busy, done, mem_addr, out_valid, out_last, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: done=%b valid=%b busy=%b, required 0 0 0",
                 done, out_valid, busy);
      end
      @(negedge clk);
    end
    run_stream(3'd0, 4'd1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      run_stream(AW'($urandom), (AW+1)'($urandom_range(0, 15)), 2,
                 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) bank[i] = 16'h1000 + 16'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_alternating();
    test_backpressure();
    test_zero_length();
    test_start_rules();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
